// File: rtl/load_store_unit.sv
// Load/store initiator for the data memory port: one request in flight, holds stores
// until write_done, extends load data. Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_is_store,
  input  logic [1:0]                        req_size,
  input  logic                              req_unsigned,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]             req_wdata,
  output logic                              resp_valid,
  output logic [DATA_WIDTH-1:0]             resp_rdata,
  output logic                              resp_fault,
  output logic [ADDR_WIDTH-1:0]             fetch_addr,
  input  logic [DATA_WIDTH-1:0]             fetched_data,
  input  logic                              fetch_done,
  output logic [ADDR_WIDTH-1:0]             write_addr,
  output logic [DATA_WIDTH-1:0]             write_data,
  output logic [$clog2(DATA_WIDTH/8):0]     bytes_to_write,
  output logic                              write_activate,
  input  logic                              write_done
);
  localparam int BW = $clog2(DATA_WIDTH/8) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, RESP} state_t;
  state_t state;

  logic [1:0]            sz_q;
  logic                  uns_q;
  logic                  misalign;
  logic                  bad_req;
  logic                  ext_bit;
  logic [DATA_WIDTH-1:0] load_ext;

  assign req_ready = (state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misalign = ((req_size == 2'd1) && req_addr[0]) ||
               ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  end
`else
  // Memory is byte-addressed, so misaligned accesses pass straight through.
  always_comb misalign = 1'b0;
`endif

  assign bad_req = (req_size == 2'd3) || misalign;

  always_comb begin
    ext_bit  = 1'b0;
    load_ext = fetched_data;
    case (sz_q)
      2'd0: begin
        ext_bit  = ~uns_q & fetched_data[7];
        load_ext = {{(DATA_WIDTH-8){ext_bit}}, fetched_data[7:0]};
      end
      2'd1: begin
        ext_bit  = ~uns_q & fetched_data[15];
        load_ext = {{(DATA_WIDTH-16){ext_bit}}, fetched_data[15:0]};
      end
      default: load_ext = fetched_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sz_q           <= 2'd0;
      uns_q          <= 1'b0;
      resp_valid     <= 1'b0;
      resp_fault     <= 1'b0;
      resp_rdata     <= '0;
      fetch_addr     <= '0;
      write_addr     <= '0;
      write_data     <= '0;
      bytes_to_write <= '0;
      write_activate <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          sz_q  <= req_size;
          uns_q <= req_unsigned;
          if (bad_req) begin
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
            resp_rdata <= '0;
            state      <= RESP;
          end else if (req_is_store) begin
            write_addr     <= req_addr;
            write_data     <= req_wdata;
            bytes_to_write <= BW'(1) << req_size;
            write_activate <= 1'b1;
            state          <= STORE;
          end else begin
            fetch_addr <= req_addr;
            state      <= LOAD;
          end
        end
        LOAD: if (fetch_done) begin
          resp_rdata <= load_ext;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          state      <= RESP;
        end
        // write_activate stays up until the memory acknowledges the commit.
        STORE: if (write_done) begin
          write_activate <= 1'b0;
          resp_rdata     <= '0;
          resp_valid     <= 1'b1;
          resp_fault     <= 1'b0;
          state          <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses,
// a negedge monitor pops and compares them.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] fetch_addr;
  logic [31:0] fetched_data = '0;
  logic        fetch_done = 1'b0;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [2:0]  bytes_to_write;
  logic        write_activate;
  logic        write_done = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct packed { logic [31:0] rdata; logic fault; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .fetch_addr(fetch_addr), .fetched_data(fetched_data),
    .fetch_done(fetch_done), .write_addr(write_addr), .write_data(write_data),
    .bytes_to_write(bytes_to_write), .write_activate(write_activate),
    .write_done(write_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: got rdata 0x%08h fault %0b, expected none", resp_rdata, resp_fault);
      end else begin
        e = sb.pop_front();
        if (resp_rdata !== e.rdata || resp_fault !== e.fault) begin
          fails++;
          $display("FAIL resp: got rdata 0x%08h fault %0b expected rdata 0x%08h fault %0b",
                   resp_rdata, resp_fault, e.rdata, e.fault);
        end
      end
    end
  end

  task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] fdata, input int delay,
                        input logic [31:0] exp_rdata, input logic exp_fault);
    int wa_cnt = 0;
    bit got = 0;
    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; fetched_data = fdata;
    fetch_done = !st;
    sb.push_back('{rdata: exp_rdata, fault: exp_fault});
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!exp_fault && st) begin
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        if (write_activate) wa_cnt++;
        if (i == 0) begin
          check("ready_busy", {31'd0, req_ready}, 32'd0);
          check("write_addr", write_addr, addr);
          check("write_data", write_data, wdata);
          check("bytes_to_write", {29'd0, bytes_to_write}, 32'd1 << sz);
        end
        if (i == delay - 1) write_done = 1'b1;
      end
      @(posedge clk); #1;
      write_done = 1'b0;
      check("wa_cycles", wa_cnt, delay);
    end else if (!exp_fault) begin
      @(negedge clk);
      check("fetch_addr", fetch_addr, addr);
      check("ready_busy", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      fetch_done = 1'b0;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = resp_valid;
    end
    check("resp_seen", {31'd0, got}, 32'd1);
    check("ready_in_resp", {31'd0, req_ready}, 32'd0);
    check("wa_in_resp", {31'd0, write_activate}, 32'd0);
    fetch_done = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_wa", {31'd0, write_activate}, 32'd0);
    check("rst_bytes", {29'd0, bytes_to_write}, 32'd0);
    check("rst_waddr", write_addr, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_req(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 5, 32'h0, 0);
    do_req(0, 2'd0, 0, 32'h100, 0, 32'h000000EF, 0, 32'hFFFFFFEF, 0);
    do_req(0, 2'd0, 1, 32'h100, 0, 32'h000000EF, 0, 32'h000000EF, 0);
    do_req(0, 2'd1, 0, 32'h200, 0, 32'h12348001, 0, 32'hFFFF8001, 0);
    do_req(0, 2'd1, 1, 32'h200, 0, 32'h12348001, 0, 32'h00008001, 0);
    do_req(0, 2'd2, 0, 32'h204, 0, 32'h92348001, 0, 32'h92348001, 0);
    do_req(0, 2'd0, 0, 32'h101, 0, 32'hABCD127F, 0, 32'h0000007F, 0);
    do_req(1, 2'd0, 0, 32'hFFF, 32'h00000001, 0, 1, 32'h0, 0);
    do_req(1, 2'd1, 0, 32'h300, 32'h0000CAFE, 0, 3, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1, 2'd2, 0, 32'h102, 32'h11223344, 0, 2, 32'h0, 1);
    do_req(0, 2'd1, 0, 32'h103, 0, 32'h0000FFFF, 0, 32'h0, 1);
`else
    do_req(1, 2'd2, 0, 32'h102, 32'h11223344, 0, 2, 32'h0, 0);
    do_req(0, 2'd1, 0, 32'h103, 0, 32'h0000FFFF, 0, 32'hFFFFFFFF, 0);
`endif
    do_req(0, 2'd3, 0, 32'h100, 0, 32'h12345678, 0, 32'h0, 1);
    do_req(1, 2'd3, 0, 32'h100, 32'h12345678, 0, 4, 32'h0, 1);

    // Reset two cycles into a store wait: store is abandoned, no response.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'd2; req_addr = 32'h400;
    req_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("wa_before_rst", {31'd0, write_activate}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("wa_async_rst", {31'd0, write_activate}, 32'd0);
    check("resp_async_rst", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ready_after_rst", {31'd0, req_ready}, 32'd1);
      check("no_resp_after_rst", {31'd0, resp_valid}, 32'd0);
    end

    do_req(0, 2'd0, 0, 32'h10, 0, 32'h00000080, 0, 32'hFFFFFF80, 0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data memory port: accepts one load or store request at a time from the execute stage and drives the memory's fetch and write interface. It holds the store until the memory signals `write_done`, captures load data on `fetch_done`, and returns a single-cycle response. Loads are sign- or zero-extended; the store byte count is derived from the access size. Sits between the CPU core's execute stage and `memory`.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; must be a multiple of 8 (4 bytes at default).
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data, LSB-aligned.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores.
- `resp_fault`  out  1  request rejected, qualified by `resp_valid`.
- `fetch_addr`  out  ADDR_WIDTH  memory load address.
- `fetched_data`  in  DATA_WIDTH  memory load data.
- `fetch_done`  in  1  `fetched_data` valid this cycle.
- `write_addr`  out  ADDR_WIDTH  memory store address.
- `write_data`  out  DATA_WIDTH  memory store data.
- `bytes_to_write`  out  $clog2(DATA_WIDTH/8)+1  bytes to store: 1, 2 or 4.
- `write_activate`  out  1  store request to memory.
- `write_done`  in  1  store commits at the next posedge.

## Operation
- States: IDLE, LOAD, STORE, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch addr, size, unsigned, wdata and type.
  - Illegal size (3) -> RESP with fault.
  - Otherwise store -> STORE, load -> LOAD.
- **LOAD**
  - `fetch_addr` = latched addr.
  - On a posedge with `fetch_done` = 1, capture `fetched_data`, apply the extension below, and go to RESP.
- **Load extension**
  - Byte: bit 7 extends; half: bit 15 extends; word: unchanged.
  - `req_unsigned` = 1 forces zero-extension.
- **STORE**
  - `write_activate` = 1.
  - `write_addr` and `write_data` hold the latched values.
  - `bytes_to_write` = 1 << size.
  - On a posedge with `write_done` = 1, deassert `write_activate` and go to RESP.
  - `write_activate` is never dropped before `write_done`.
- **RESP**
  - `resp_valid` = 1 for exactly one cycle, then IDLE.
  - No response backpressure.
- **Registered outputs**
  - `fetch_addr`, `write_addr`, `write_data`, `bytes_to_write` and `resp_rdata` are registered and hold their value outside use.
  - `resp_rdata` = 0 for stores and faults.
- **Reset values**
  - state = IDLE, `write_activate` = 0, `resp_valid` = 0, `resp_fault` = 0.
  - All address and data outputs = 0; `bytes_to_write` = 0.
- **Reset mid-operation**
  - Asserting `rst_n` low forces IDLE and `write_activate` = 0 asynchronously.
  - An outstanding store is abandoned; no response is produced.

## Timing
- Request accepted at posedge N (`req_valid` && `req_ready`).
- Load with `fetch_done` tied high:
  - LOAD during cycle N..N+1; data captured at N+1.
  - `resp_valid` high N+1..N+2, so the load completes in 2 cycles.
- Store:
  - `write_activate` high from N.
  - If `write_done` is first high in cycle k, the store commits at edge k and `resp_valid` is high the following cycle.
  - Against `memory`, the wait is at most 16 cycles.
- Fault: `resp_valid` high N..N+1 with `resp_fault` = 1; no memory activity.
- Next request is accepted no earlier than the edge that ends RESP, so issue is at most one request per 2 cycles.
- `req_ready` is combinational from state only, never from `req_valid`.

## Configuration
- `LSU_MISALIGN_TRAP_EN`:
  - Defined: a half access with addr[0] = 1 or a word access with addr[1:0] ≠ 0 goes IDLE -> RESP with `resp_fault` = 1, without touching memory.
  - Undefined: misaligned accesses are issued unchanged (memory is byte-addressed) and never fault; only size 3 faults.

## Test plan
- Store word 0xDEADBEEF to 0x100 with `write_done` first high 5 cycles after accept -> `write_activate` high 5 cycles, `bytes_to_write` = 4, `resp_valid` pulse, `resp_fault` = 0.
- Load byte from 0x100 with `req_unsigned` = 0 and `fetched_data` = 0x000000EF -> `resp_rdata` = 0xFFFFFFEF; same load with `req_unsigned` = 1 -> 0x000000EF.
- Load half with `fetched_data` = 0x12348001 -> signed 0xFFFF8001, unsigned 0x00008001.
- Store byte 0x01 to 0xFFF -> `bytes_to_write` = 1, `write_addr` = 0xFFF, `write_data` = 0x01; `req_ready` stays 0 until after the response.
- Word access to 0x102: macro defined -> `resp_fault` = 1, `write_activate` never asserted; undefined -> store issued normally; `req_size` = 3 -> fault in both builds.
- Drop `rst_n` low two cycles into a store wait -> `write_activate` = 0 immediately, no `resp_valid`, `req_ready` = 1 after release.
